// File: rtl/ram_arbiter_pkg.sv
// Shared constants and helpers for the round-robin RAM arbiter.
package ram_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_NUM_REQ    = 4;
    localparam int MAX_REQ        = 8;

    // Returns a MAX_REQ-wide vector with only bit idx set; zero when idx >= n.
    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_REQ-1:0] v;
        v = '0;
        if (idx < n && idx < MAX_REQ) begin
            v[idx[2:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
import ram_arbiter_pkg::*;

module rr_pick #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   win,
    output logic               valid
);

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        return PTR_W'((int'(base) + off) % NUM_REQ);
    endfunction

    // Scan from the farthest offset down so the nearest hit to ptr is the last one written.
    always_comb begin
        valid = 1'b0;
        win   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[wrap_add(ptr, i)]) begin
                valid = 1'b1;
                win   = wrap_add(ptr, i);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port-per-cycle synchronous RAM among NUM_REQ clients and routes
// read data back to the requester that issued the read one cycle earlier.
import ram_arbiter_pkg::*;

module ram_arbiter #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            wr,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          ram_we,
    output logic                          ram_re,
    output logic [ADDR_WIDTH-1:0]         ram_wr_addr,
    output logic [ADDR_WIDTH-1:0]         ram_rd_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    input  logic [DATA_WIDTH-1:0]         ram_dout
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [PTR_W-1:0]      rd_tag_q, rd_tag_d;

    logic [PTR_W-1:0]      pick_win;
    logic                  pick_vld;
    logic                  grant;
    logic                  win_wr;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;
    logic [MAX_REQ-1:0]    gnt_full;
    logic [MAX_REQ-1:0]    rvalid_full;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .win   (pick_win),
        .valid (pick_vld)
    );

    always_comb begin
        grant     = pick_vld && !rst;
        win_wr    = wr[pick_win];
        addr_sel  = addr[int'(pick_win)*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_sel = wdata[int'(pick_win)*DATA_WIDTH +: DATA_WIDTH];
        gnt_full  = grant ? onehot(32'(pick_win), NUM_REQ) : '0;
        gnt       = gnt_full[NUM_REQ-1:0];

        ram_we      = grant && win_wr;
        ram_re      = grant && !win_wr;
        ram_wr_addr = ram_we ? addr_sel  : '0;
        ram_din     = ram_we ? wdata_sel : '0;
        ram_rd_addr = ram_re ? addr_sel  : '0;

        ptr_d = ptr_q;
        if (grant) begin
            if (lock[pick_win]) begin
                ptr_d = pick_win;
            end else if (pick_win == PTR_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = pick_win + 1'b1;
            end
        end

        rd_pend_d = ram_re;
        rd_tag_d  = pick_win;
    end

    // Return path: the RAM's registered output lines up with the read issued last cycle.
    always_comb begin
        rvalid_full = (rd_pend_q && !rst) ? onehot(32'(rd_tag_q), NUM_REQ) : '0;
        rvalid      = rvalid_full[NUM_REQ-1:0];
        rdata       = (rd_pend_q && !rst) ? ram_dout : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_tag_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed, table-driven bench for ram_arbiter with a behavioural synchronous RAM.
module tb_ram_arbiter;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NR = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req, wr, lock;
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] wdata;
    logic [NR-1:0]  gnt, rvalid;
    logic [DW-1:0]  rdata;
    logic           ram_we, ram_re;
    logic [AW-1:0]  ram_wr_addr, ram_rd_addr;
    logic [DW-1:0]  ram_din, ram_dout;

    logic [DW-1:0]  mem [0:255];

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .wr          (wr),
        .lock        (lock),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .ram_we      (ram_we),
        .ram_re      (ram_re),
        .ram_wr_addr (ram_wr_addr),
        .ram_rd_addr (ram_rd_addr),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout)
    );

    // Synchronous RAM: write commits at the edge, read data is registered.
    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_rd_addr];
    end

    typedef struct {
        logic          rst;
        logic [3:0]    req, wr, lock;
        logic [31:0]   addr, wdata;
        logic [3:0]    gnt;
        logic          we, re;
        logic [7:0]    wa, ra, din;
        logic [3:0]    rvalid;
        logic [7:0]    rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] w, input logic [3:0] lk,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] g, input logic we, input logic re,
                       input logic [7:0] wa, input logic [7:0] ra, input logic [7:0] din,
                       input logic [3:0] rv, input logic [7:0] rd);
        vec_t v;
        v.rst = r; v.req = rq; v.wr = w; v.lock = lk; v.addr = a; v.wdata = d;
        v.gnt = g; v.we = we; v.re = re; v.wa = wa; v.ra = ra; v.din = din;
        v.rvalid = rv; v.rdata = rd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    localparam logic [31:0] A_STD = {8'h13, 8'h12, 8'h11, 8'h10};
    localparam logic [31:0] A_RAW = {8'h13, 8'h12, 8'h20, 8'h20};

    initial begin
        int cnt [NR];
        int both_err;

        for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
        rst = 1'b1; req = '0; wr = '0; lock = '0; addr = '0; wdata = '0;

        //   rst req     wr      lock    addr   wdata        gnt     we re wa     ra     din    rvalid  rdata
        add(1, 4'b0000, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b0000, 0, 0, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h00);
        add(1, 4'b1111, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b0000, 0, 0, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h00);
        add(0, 4'b0000, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b0000, 0, 0, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h00);
        add(0, 4'b0001, 4'b0001, 4'b0000, A_STD, 32'hA5,     4'b0001, 1, 0, 8'h10, 8'h00, 8'hA5, 4'b0000, 8'h00);
        add(0, 4'b0001, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b0001, 0, 1, 8'h00, 8'h10, 8'h00, 4'b0000, 8'h00);
        add(0, 4'b1000, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b1000, 0, 1, 8'h00, 8'h13, 8'h00, 4'b0001, 8'hA5);
        add(0, 4'b1111, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b0001, 0, 1, 8'h00, 8'h10, 8'h00, 4'b1000, 8'hEC);
        add(0, 4'b1111, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b0010, 0, 1, 8'h00, 8'h11, 8'h00, 4'b0001, 8'hA5);
        add(0, 4'b1111, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b0100, 0, 1, 8'h00, 8'h12, 8'h00, 4'b0010, 8'hEE);
        add(0, 4'b1111, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b1000, 0, 1, 8'h00, 8'h13, 8'h00, 4'b0100, 8'hED);
        add(0, 4'b1111, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b0001, 0, 1, 8'h00, 8'h10, 8'h00, 4'b1000, 8'hEC);
        add(0, 4'b0110, 4'b0000, 4'b0010, A_STD, 32'h0,      4'b0010, 0, 1, 8'h00, 8'h11, 8'h00, 4'b0001, 8'hA5);
        add(0, 4'b0110, 4'b0000, 4'b0010, A_STD, 32'h0,      4'b0010, 0, 1, 8'h00, 8'h11, 8'h00, 4'b0010, 8'hEE);
        add(0, 4'b0110, 4'b0000, 4'b0010, A_STD, 32'h0,      4'b0010, 0, 1, 8'h00, 8'h11, 8'h00, 4'b0010, 8'hEE);
        add(0, 4'b0110, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b0010, 0, 1, 8'h00, 8'h11, 8'h00, 4'b0010, 8'hEE);
        add(0, 4'b0110, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b0100, 0, 1, 8'h00, 8'h12, 8'h00, 4'b0010, 8'hEE);
        add(0, 4'b1000, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b1000, 0, 1, 8'h00, 8'h13, 8'h00, 4'b0100, 8'hED);
        add(0, 4'b0011, 4'b0001, 4'b0000, A_RAW, 32'h3C,     4'b0001, 1, 0, 8'h20, 8'h00, 8'h3C, 4'b1000, 8'hEC);
        add(0, 4'b0010, 4'b0000, 4'b0000, A_RAW, 32'h0,      4'b0010, 0, 1, 8'h00, 8'h20, 8'h00, 4'b0000, 8'h00);
        add(0, 4'b0000, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b0000, 0, 0, 8'h00, 8'h00, 8'h00, 4'b0010, 8'h3C);
        add(0, 4'b0100, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b0100, 0, 1, 8'h00, 8'h12, 8'h00, 4'b0000, 8'h00);
        add(1, 4'b0100, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b0000, 0, 0, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h00);
        add(0, 4'b0000, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b0000, 0, 0, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h00);
        add(0, 4'b1111, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b0001, 0, 1, 8'h00, 8'h10, 8'h00, 4'b0000, 8'h00);
        add(0, 4'b0000, 4'b0000, 4'b0000, A_STD, 32'h0,      4'b0000, 0, 0, 8'h00, 8'h00, 8'h00, 4'b0001, 8'hA5);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst = vecs[i].rst; req = vecs[i].req; wr = vecs[i].wr; lock = vecs[i].lock;
            addr = vecs[i].addr; wdata = vecs[i].wdata;
            #3;
            check($sformatf("vec%0d {gnt,we,re,wa,ra,din,rvalid,rdata}", i),
                  64'({gnt, ram_we, ram_re, ram_wr_addr, ram_rd_addr, ram_din, rvalid, rdata}),
                  64'({vecs[i].gnt, vecs[i].we, vecs[i].re, vecs[i].wa, vecs[i].ra,
                       vecs[i].din, vecs[i].rvalid, vecs[i].rdata}));
        end

        // Fairness with mixed writes and reads: 8 cycles, every requester twice.
        for (int k = 0; k < NR; k++) cnt[k] = 0;
        both_err = 0;
        for (int c = 0; c < 2 * NR; c++) begin
            @(posedge clk);
            #1;
            rst = 1'b0; req = 4'b1111; wr = 4'b0101; lock = 4'b0000;
            addr = {8'h33, 8'h32, 8'h31, 8'h30}; wdata = {8'h44, 8'h43, 8'h42, 8'h41};
            #3;
            for (int k = 0; k < NR; k++) if (gnt[k]) cnt[k]++;
            if ((ram_we && ram_re) || $countones(gnt) != 1) both_err++;
        end
        for (int k = 0; k < NR; k++) check($sformatf("fair_cnt%0d", k), 64'(cnt[k]), 64'd2);
        check("we_re_exclusive_onehot_gnt", 64'(both_err), 64'd0);

        // Written words from the fairness loop are read back through the return path.
        @(posedge clk);
        #1;
        req = 4'b0001; wr = 4'b0000; addr = {8'h00, 8'h00, 8'h00, 8'h32};
        #3;
        check("readback_gnt", 64'(gnt), 64'(4'b0001));
        @(posedge clk);
        #1;
        req = 4'b0000;
        #3;
        check("readback_data", 64'({rvalid, rdata}), 64'({4'b0001, 8'h43}));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
